uart_mem_ctrl: RTL and testbench

Command initiator that sits between the UART receiver/transmitter and the 16×8 register memory. It parses a byte stream from the UART RX path into memory write and read transactions, and drives the memory's addr/wr_mem/rd_mem port. It returns read data to the host through the UART TX path. It is the bus master the memory responds to.

---
 rtl/uart_mem_pkg.sv | 27 ++
 rtl/uart_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_uart_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_pkg.sv
// Shared definitions for the UART command initiator: FSM states, command
// byte field positions and the error response byte.
package uart_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_MEM,
        ST_RD_MEM,
        ST_RD_CAP,
        ST_TX_WAIT
    } state_e;

    localparam int CMD_WR_BIT       = 7;
    localparam int CMD_RSVD_MSB     = 6;
    localparam int CMD_RSVD_LSB     = 4;
    localparam int CMD_ADDR_MSB     = 3;
    localparam int CMD_ADDR_LSB     = 0;

    localparam logic [7:0] ERR_BYTE = 8'hEE;

    // A command is only legal when its reserved field is all zeros.
    function automatic logic cmd_is_valid(input logic [7:0] cmd);
        return (cmd[CMD_RSVD_MSB:CMD_RSVD_LSB] == 3'b000);
    endfunction

endpackage

// File: rtl/uart_mem_ctrl.sv
// Byte-stream command parser driving the 16x8 register memory and returning
// read data over UART TX. Define UART_MEM_ERR_RESP_EN to answer invalid commands with 0xEE.
module uart_mem_ctrl
    import uart_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [3:0] addr,
    output logic [7:0] wr_mem_data,
    output logic       wr_mem,
    output logic       rd_mem,
    input  logic [7:0] rd_mem_data,
    output logic       busy,
    output logic       overrun
);

    state_e     state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wr_mem_data_q, wr_mem_data_d;
    logic       wr_mem_q, wr_mem_d;
    logic       rd_mem_q, rd_mem_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        addr_d        = addr_q;
        wr_mem_data_d = wr_mem_data_q;
        wr_mem_d      = 1'b0;
        rd_mem_d      = 1'b0;
        overrun_d     = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (!cmd_is_valid(rx_data)) begin
`ifdef UART_MEM_ERR_RESP_EN
                        tx_data_d = ERR_BYTE;
                        state_d   = ST_TX_WAIT;
`else
                        state_d   = ST_IDLE;
`endif
                    end else if (rx_data[CMD_WR_BIT]) begin
                        addr_d  = rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
                        state_d = ST_WR_DATA;
                    end else begin
                        addr_d   = rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
                        rd_mem_d = 1'b1;
                        state_d  = ST_RD_MEM;
                    end
                end
            end
            ST_WR_DATA: begin
                if (rx_valid) begin
                    wr_mem_data_d = rx_data;
                    wr_mem_d      = 1'b1;
                    state_d       = ST_WR_MEM;
                end
            end
            ST_WR_MEM: state_d = ST_IDLE;
            ST_RD_MEM: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                // Memory output is registered, so it is valid one cycle after rd_mem.
                tx_data_d = rd_mem_data;
                state_d   = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bytes arriving while a strobe or response is in flight cannot be used.
        if (rx_valid && (state_q == ST_WR_MEM || state_q == ST_RD_MEM ||
                         state_q == ST_RD_CAP || state_q == ST_TX_WAIT)) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            addr_q        <= 4'h0;
            wr_mem_data_q <= 8'h00;
            wr_mem_q      <= 1'b0;
            rd_mem_q      <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            addr_q        <= addr_d;
            wr_mem_data_q <= wr_mem_data_d;
            wr_mem_q      <= wr_mem_d;
            rd_mem_q      <= rd_mem_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign addr        = addr_q;
    assign wr_mem_data = wr_mem_data_q;
    assign wr_mem      = wr_mem_q;
    assign rd_mem      = rd_mem_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// Self-checking bench for uart_mem_ctrl with a 16x8 registered-read memory model.
// Honors UART_MEM_ERR_RESP_EN the same way the design does.
module tb_uart_mem_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [3:0] addr;
    logic [7:0] wr_mem_data;
    logic       wr_mem;
    logic       rd_mem;
    logic [7:0] rd_mem_data;
    logic       busy;
    logic       overrun;

    int tests_run;
    int tests_failed;

    int wr_cnt;
    int rd_cnt;
    int tx_cnt;
    int both_strobes;
    int tx_while_busy;

    logic [7:0] mem [16];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        int         gap;
        logic       exp_tx;
        logic [7:0] exp_tx_data;
    } vec_t;

    vec_t vecs [9];

`ifdef UART_MEM_ERR_RESP_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    uart_mem_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .addr        (addr),
        .wr_mem_data (wr_mem_data),
        .wr_mem      (wr_mem),
        .rd_mem      (rd_mem),
        .rd_mem_data (rd_mem_data),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register memory the controller masters: synchronous write, registered read.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rd_mem_data = 8'h00;
    end

    always @(posedge clk) begin
        if (wr_mem) mem[addr] <= wr_mem_data;
        if (rd_mem) rd_mem_data <= mem[addr];
    end

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_mem) wr_cnt++;
        if (rd_mem) rd_cnt++;
        if (tx_start) tx_cnt++;
        if (wr_mem && rd_mem) both_strobes++;
        if (tx_start && tx_busy) tx_while_busy++;
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was sampled.
    task automatic sendByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {7'd0, busy}, 8'h00);
    endtask

    task automatic waitTx(input string name, output logic seen);
        int n;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            if (tx_start === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput(name, {7'd0, seen}, 8'h01);
    endtask

    task automatic applyStimulus(input vec_t v);
        int   wr0, tx0;
        logic seen;
        wr0 = wr_cnt;
        tx0 = tx_cnt;
        if (v.cmd[6:4] != 3'b000) begin
            sendByte(v.cmd);
            checkOutput("inv_busy", {7'd0, busy}, {7'd0, ERR_EN});
            repeat (6) @(negedge clk);
            checkOutput("inv_tx_cnt", 8'(tx_cnt - tx0), {7'd0, v.exp_tx});
            if (v.exp_tx) checkOutput("inv_tx_data", tx_data, v.exp_tx_data);
        end else if (v.cmd[7]) begin
            sendByte(v.cmd);
            checkOutput("wr_busy_rise", {7'd0, busy}, 8'h01);
            repeat (v.gap) @(negedge clk);
            checkOutput("wr_no_early_strobe", {7'd0, wr_mem}, 8'h00);
            sendByte(v.data);
            checkOutput("wr_strobe", {7'd0, wr_mem}, 8'h01);
            checkOutput("wr_addr", {4'd0, addr}, {4'd0, v.cmd[3:0]});
            checkOutput("wr_data", wr_mem_data, v.data);
            @(negedge clk);
            checkOutput("wr_busy_fall", {7'd0, busy}, 8'h00);
            checkOutput("wr_strobe_single", {7'd0, wr_mem}, 8'h00);
            checkOutput("wr_cnt", 8'(wr_cnt - wr0), 8'h01);
        end else begin
            sendByte(v.cmd);
            checkOutput("rd_strobe", {7'd0, rd_mem}, 8'h01);
            checkOutput("rd_addr", {4'd0, addr}, {4'd0, v.cmd[3:0]});
            checkOutput("rd_busy", {7'd0, busy}, 8'h01);
            @(negedge clk);
            checkOutput("rd_no_early_tx", {7'd0, tx_start}, 8'h00);
            waitTx("rd_tx_seen", seen);
            checkOutput("rd_tx_data", tx_data, v.exp_tx_data);
            waitIdle("rd_idle");
        end
    endtask

    initial begin
        logic seen;
        int   rd0, wr0, tx0, early;

        tests_run     = 0;
        tests_failed  = 0;
        wr_cnt        = 0;
        rd_cnt        = 0;
        tx_cnt        = 0;
        both_strobes  = 0;
        tx_while_busy = 0;
        rx_data       = 8'h00;
        rx_valid      = 1'b0;
        tx_busy       = 1'b0;
        rst_n         = 1'b0;

        vecs[0] = '{cmd: 8'h83, data: 8'h5A, gap: 0, exp_tx: 1'b0, exp_tx_data: 8'h00};
        vecs[1] = '{cmd: 8'h03, data: 8'h00, gap: 0, exp_tx: 1'b1, exp_tx_data: 8'h5A};
        vecs[2] = '{cmd: 8'h0F, data: 8'h00, gap: 0, exp_tx: 1'b1, exp_tx_data: 8'h00};
        vecs[3] = '{cmd: 8'h8F, data: 8'hA5, gap: 5, exp_tx: 1'b0, exp_tx_data: 8'h00};
        vecs[4] = '{cmd: 8'h0F, data: 8'h00, gap: 0, exp_tx: 1'b1, exp_tx_data: 8'hA5};
        vecs[5] = '{cmd: 8'h80, data: 8'h11, gap: 2, exp_tx: 1'b0, exp_tx_data: 8'h00};
        vecs[6] = '{cmd: 8'h00, data: 8'h00, gap: 0, exp_tx: 1'b1, exp_tx_data: 8'h11};
        vecs[7] = '{cmd: 8'h90, data: 8'h00, gap: 0, exp_tx: ERR_EN, exp_tx_data: 8'hEE};
        vecs[8] = '{cmd: 8'h03, data: 8'h00, gap: 0, exp_tx: 1'b1, exp_tx_data: 8'h5A};

        repeat (3) @(negedge clk);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_busy", {7'd0, busy}, 8'h00);
        checkOutput("rst_strobes", {5'd0, tx_start, wr_mem, rd_mem}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
        end

        // Back-pressure: response must wait for tx_busy, then go one cycle after it drops.
        tx_busy = 1'b1;
        tx0 = tx_cnt;
        sendByte(8'h03);
        early = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_start) early++;
        end
        checkOutput("bp_held", 8'(early), 8'h00);
        checkOutput("bp_busy_held", {7'd0, busy}, 8'h01);
        tx_busy = 1'b0;
        @(negedge clk);
        checkOutput("bp_tx_start", {7'd0, tx_start}, 8'h01);
        checkOutput("bp_tx_data", tx_data, 8'h5A);
        @(negedge clk);
        checkOutput("bp_tx_once", 8'(tx_cnt - tx0), 8'h01);
        waitIdle("bp_idle");

        // Overrun: second byte one cycle after a read command is dropped.
        checkOutput("ovr_clear", {7'd0, overrun}, 8'h00);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        sendByte(8'h01);
        sendByte(8'h85);
        checkOutput("ovr_set", {7'd0, overrun}, 8'h01);
        waitTx("ovr_tx_seen", seen);
        checkOutput("ovr_tx_data", tx_data, 8'h00);
        waitIdle("ovr_idle");
        repeat (4) @(negedge clk);
        checkOutput("ovr_rd_cnt", 8'(rd_cnt - rd0), 8'h01);
        checkOutput("ovr_wr_cnt", 8'(wr_cnt - wr0), 8'h00);
        checkOutput("ovr_sticky", {7'd0, overrun}, 8'h01);

        // Reset while waiting for write data: everything returns to reset values.
        sendByte(8'h87);
        checkOutput("rstw_busy", {7'd0, busy}, 8'h01);
        #2 rst_n = 1'b0;
        #2;
        checkOutput("rstw_addr", {4'd0, addr}, 8'h00);
        checkOutput("rstw_wdata", wr_mem_data, 8'h00);
        checkOutput("rstw_tx_data", tx_data, 8'h00);
        checkOutput("rstw_flags", {3'd0, busy, overrun, tx_start, wr_mem, rd_mem}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr0 = wr_cnt;
        sendByte(8'h05);
        waitIdle("rstw_idle");
        repeat (4) @(negedge clk);
        checkOutput("rstw_no_write", 8'(wr_cnt - wr0), 8'h00);
        checkOutput("rstw_mem7", mem[7], 8'h00);

        checkOutput("never_both_strobes", 8'(both_strobes), 8'h00);
        checkOutput("never_tx_while_busy", 8'(tx_while_busy), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
